// File: rtl/fan_pkg.sv
// Shared constants and helpers for the multi-channel fan PWM / tach controller.
`timescale 1ns/1ps
`default_nettype none

package fan_pkg;

  localparam int DEF_PWM_W    = 8;
  localparam int DEF_TACH_W   = 11;
  localparam int DEF_TACH_MAX = 'h3FF;

  // Common duty presets for an 8-bit duty field.
  localparam logic [DEF_PWM_W-1:0] FAN_PCT_0   = 8'd0;
  localparam logic [DEF_PWM_W-1:0] FAN_PCT_25  = 8'd64;
  localparam logic [DEF_PWM_W-1:0] FAN_PCT_50  = 8'd128;
  localparam logic [DEF_PWM_W-1:0] FAN_PCT_75  = 8'd192;
  localparam logic [DEF_PWM_W-1:0] FAN_PCT_100 = 8'd255;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int fan_clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fan_tach_ch.sv
// One tach channel: synchroniser, glitch filter, edge detect, window counter and stall qualifier.
`timescale 1ns/1ps
`default_nettype none

module fan_tach_ch
  import fan_pkg::*;
#(
  parameter int TACH_W    = DEF_TACH_W,
  parameter int TACH_MAX  = DEF_TACH_MAX,
  parameter int FILT_CYC  = 4,
  parameter int STALL_WIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tach,
  input  logic              win_tick,
  input  logic              update,
  input  logic              fan_on,
  input  logic [TACH_W-1:0] stall_thr,
  output logic [TACH_W-1:0] tach_cnt,
  output logic              present,
  output logic              stall
);

  localparam int FW = fan_clog2(FILT_CYC + 1);
  localparam int LW = fan_clog2(STALL_WIN + 1);
  localparam logic [FW-1:0]     FILT_LAST = FW'(FILT_CYC - 1);
  localparam logic [LW-1:0]     LOW_MAX   = LW'(STALL_WIN);
  localparam logic [TACH_W-1:0] CNT_MAX   = TACH_W'(TACH_MAX);

  logic              sync1;
  logic              sync2;
  logic              filt;
  logic              filt_d;
  logic [FW-1:0]     stab;
  logic [TACH_W-1:0] win_cnt;
  logic [LW-1:0]     low_cnt;
  logic [LW-1:0]     low_inc;
  logic              edge_pulse;
  logic              low_win;

  assign edge_pulse = filt & ~filt_d;
  assign low_win    = win_cnt < stall_thr;
  assign low_inc    = (low_cnt == LOW_MAX) ? LOW_MAX : low_cnt + LW'(1);

  // The filtered level only follows the synchronised input once it has
  // disagreed for FILT_CYC consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      stab   <= '0;
    end else begin
      sync1  <= tach;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 == filt) begin
        stab <= '0;
      end else if (stab == FILT_LAST) begin
        filt <= sync2;
        stab <= '0;
      end else begin
        stab <= stab + FW'(1);
      end
    end
  end

  // An edge coinciding with the window boundary belongs to the new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (win_tick) begin
      win_cnt <= TACH_W'(edge_pulse);
    end else if (edge_pulse && (win_cnt != CNT_MAX)) begin
      win_cnt <= win_cnt + TACH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tach_cnt <= '0;
      present  <= 1'b0;
      stall    <= 1'b0;
      low_cnt  <= '0;
    end else if (update) begin
      tach_cnt <= win_cnt;
      present  <= |win_cnt;
      if (!fan_on) begin
        low_cnt <= '0;
        stall   <= 1'b0;
      end else if (low_win) begin
        low_cnt <= low_inc;
        stall   <= (low_inc == LOW_MAX);
      end else begin
        low_cnt <= '0;
        stall   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fan_pwm_tach_mc.sv
// Multi-channel fan controller: shared PWM period counter, per-fan PWM compare and tach monitor.
`timescale 1ns/1ps
`default_nettype none

module fan_pwm_tach_mc
  import fan_pkg::*;
#(
  parameter int NUM_FANS  = 4,
  parameter int PWM_W     = DEF_PWM_W,
  parameter int TACH_W    = DEF_TACH_W,
  parameter int TACH_MAX  = DEF_TACH_MAX,
  parameter int FILT_CYC  = 4,
  parameter int STALL_WIN = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_pwm_tick,
  input  logic                       i_win_tick,
  input  logic [PWM_W-1:0]           i_pwm_period,
  input  logic [NUM_FANS*PWM_W-1:0]  i_pwm_duty,
  input  logic [TACH_W-1:0]          i_stall_thr,
  input  logic [NUM_FANS-1:0]        i_fan_tach,
  output logic [NUM_FANS-1:0]        o_pwm,
  output logic [NUM_FANS*TACH_W-1:0] o_tach_cnt,
  output logic                       o_tach_valid,
  output logic [NUM_FANS-1:0]        o_fan_present,
  output logic [NUM_FANS-1:0]        o_fan_stall,
  output logic                       o_fan_fail_any
);

  logic [PWM_W-1:0]    pwm_cnt;
  logic [NUM_FANS-1:0] pwm_next;
  logic [NUM_FANS-1:0] fan_on;
  logic                seen_win;
  logic                win_update;

  // Wrap on >= so that lowering the period below the current count still
  // returns to zero on the next tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_cnt <= '0;
    end else if (i_pwm_tick) begin
      pwm_cnt <= (pwm_cnt >= i_pwm_period) ? '0 : pwm_cnt + PWM_W'(1);
    end
  end

  // The first window after reset is partial and never published.
  assign win_update = i_win_tick & seen_win;

  generate
    for (genvar n = 0; n < NUM_FANS; n++) begin : g_ch
      logic [PWM_W-1:0] duty;
      assign duty        = i_pwm_duty[n*PWM_W +: PWM_W];
      assign fan_on[n]   = |duty;
      assign pwm_next[n] = fan_on[n] && ((duty >= i_pwm_period) || (pwm_cnt < duty));

      fan_tach_ch #(
        .TACH_W    (TACH_W),
        .TACH_MAX  (TACH_MAX),
        .FILT_CYC  (FILT_CYC),
        .STALL_WIN (STALL_WIN)
      ) u_tach (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .tach      (i_fan_tach[n]),
        .win_tick  (i_win_tick),
        .update    (win_update),
        .fan_on    (fan_on[n]),
        .stall_thr (i_stall_thr),
        .tach_cnt  (o_tach_cnt[n*TACH_W +: TACH_W]),
        .present   (o_fan_present[n]),
        .stall     (o_fan_stall[n])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pwm        <= '0;
      o_tach_valid <= 1'b0;
      seen_win     <= 1'b0;
    end else begin
      o_pwm        <= pwm_next;
      o_tach_valid <= win_update;
      if (i_win_tick) seen_win <= 1'b1;
    end
  end

  assign o_fan_fail_any = |o_fan_stall;

endmodule

`default_nettype wire
